demux_1to2_4bit_buf: RTL and testbench

Buffered 1-to-2 stream demultiplexer: the splitting counterpart of the 2:1 4-bit selector in the basic parts library. Accepts one 4-bit word per cycle over a valid/ready handshake and steers it, by a per-word select bit, into one of two independent output FIFOs. Each FIFO drives its own valid/ready output port. Per-output transfer counters support bus-bring-up debug.

---
 rtl/demux_pkg.sv | 8 +
 rtl/sync_fifo_slot.sv | 75 +++++++
 rtl/demux_1to2_4bit_buf.sv | 92 +++++++++
 tb/tb_demux_1to2_4bit_buf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and types for the buffered 1-to-2 stream demultiplexer.
package demux_pkg;
  localparam int WIDTH_DEF = 4;  // data word width
  localparam int DEPTH_DEF = 2;  // entries per output FIFO (power of two, >= 2)
  localparam int CNT_W_DEF = 8;  // per-output delivery counter width

  typedef logic [WIDTH_DEF-1:0] data_t;
endpackage

// File: rtl/sync_fifo_slot.sv
// DEPTH-entry synchronous FIFO used as one output lane of the demultiplexer.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears storage too)
//   push, push_data write request and word; ignored while full
//   pop             read request; ignored while empty
//   full, empty     registered occupancy flags
//   head_data       word at the read pointer (registered storage only)
module sync_fifo_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == OCC_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  // Guards make the FIFO safe on its own; the top never pushes when full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register: storage is cleared on reset so head_data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/demux_1to2_4bit_buf.sv
// Buffered 1-to-2 stream demultiplexer: each accepted word is steered by
// in_sel into one of two independent FIFOs with their own valid/ready ports.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data/in_sel/in_valid    input word, route select, valid
//   in_ready                   depends only on in_sel and registered full flags
//   outN_data/valid/ready      head word, non-empty flag, consumer accept
//   cnt0, cnt1                 words delivered per output, wrapping
module demux_1to2_4bit_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic             full0, full1;
  logic             empty0, empty1;
  logic             accept;
  logic             push0, push1;
  logic             pop0, pop1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // No dependence on in_valid or outN_ready: no ready-to-ready path.
  assign in_ready = in_sel ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && !in_sel;
  assign push1    = accept &&  in_sel;

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  sync_fifo_slot #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head_data (out0_data)
  );

  sync_fifo_slot #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head_data (out1_data)
  );

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + 1'b1;
    if (pop1) cnt1_d = cnt1_q + 1'b1;
  end

  // Delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
endmodule

// File: tb/tb_demux_1to2_4bit_buf.sv
module tb_demux_1to2_4bit_buf;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [3:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int n_vec = 0;
  int n_err = 0;

  demux_1to2_4bit_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       v;
    logic       s;
    logic [3:0] d;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [3:0] e_d0;
    logic       e_v1;
    logic [3:0] e_d1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  function automatic vec_t mk(string name, logic v, logic s, logic [3:0] d,
                              logic r0, logic r1, logic e_rdy,
                              logic e_v0, logic [3:0] e_d0,
                              logic e_v1, logic [3:0] e_d1,
                              logic [7:0] e_c0, logic [7:0] e_c1);
    vec_t t;
    t.name = name; t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1;
    t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0; t.e_v1 = e_v1;
    t.e_d1 = e_d1; t.e_c0 = e_c0; t.e_c1 = e_c1;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic s, logic [3:0] d, logic r0, logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Behavioural reference: two bounded queues plus wrapping counters.
  logic [3:0] mq0[$];
  logic [3:0] mq1[$];
  logic [7:0] mc0, mc1;

  vec_t tbl[15];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    chk("rst_v0", 32'(out0_valid), 0);
    chk("rst_v1", 32'(out1_valid), 0);
    chk("rst_d0", 32'(out0_data), 0);
    chk("rst_d1", 32'(out1_data), 0);
    chk("rst_c0", 32'(cnt0), 0);
    chk("rst_c1", 32'(cnt1), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Expected values are the outputs seen before the edge that applies the row.
    tbl[0]  = mk("t1_w3",     1, 0, 4'h3, 1, 1, 1, 0, 4'h0, 0, 4'h0, 0, 0);
    tbl[1]  = mk("t1_w5",     1, 1, 4'h5, 1, 1, 1, 1, 4'h3, 0, 4'h0, 0, 0);
    tbl[2]  = mk("t1_w9",     1, 0, 4'h9, 1, 1, 1, 0, 4'h0, 1, 4'h5, 1, 0);
    tbl[3]  = mk("t1_idle",   0, 0, 4'h0, 1, 1, 1, 1, 4'h9, 0, 4'h0, 1, 1);
    tbl[4]  = mk("t1_done",   0, 0, 4'h0, 1, 1, 1, 0, 4'h0, 0, 4'h0, 2, 1);
    tbl[5]  = mk("t2_wA",     1, 0, 4'hA, 0, 1, 1, 0, 4'h0, 0, 4'h0, 2, 1);
    tbl[6]  = mk("t2_wB",     1, 0, 4'hB, 0, 1, 1, 1, 4'hA, 0, 4'h0, 2, 1);
    tbl[7]  = mk("t2_full",   1, 0, 4'hC, 0, 1, 0, 1, 4'hA, 0, 4'h0, 2, 1);
    tbl[8]  = mk("t3_w7",     1, 1, 4'h7, 0, 0, 1, 1, 4'hA, 0, 4'h0, 2, 1);
    tbl[9]  = mk("t2_popA",   1, 0, 4'hC, 1, 0, 0, 1, 4'hA, 1, 4'h7, 2, 1);
    tbl[10] = mk("t2_wC",     1, 0, 4'hC, 1, 0, 1, 1, 4'hB, 1, 4'h7, 3, 1);
    tbl[11] = mk("t4_pushpop",1, 1, 4'hE, 1, 1, 1, 1, 4'hC, 1, 4'h7, 4, 1);
    tbl[12] = mk("t4_head",   0, 1, 4'h0, 0, 0, 1, 0, 4'h0, 1, 4'hE, 5, 2);
    tbl[13] = mk("t4_popE",   0, 1, 4'h0, 0, 1, 1, 0, 4'h0, 1, 4'hE, 5, 2);
    tbl[14] = mk("t4_end",    0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 0, 4'h0, 5, 3);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      chk({tbl[i].name, "_rdy"}, 32'(in_ready), 32'(tbl[i].e_rdy));
      chk({tbl[i].name, "_v0"}, 32'(out0_valid), 32'(tbl[i].e_v0));
      chk({tbl[i].name, "_v1"}, 32'(out1_valid), 32'(tbl[i].e_v1));
      if (tbl[i].e_v0) chk({tbl[i].name, "_d0"}, 32'(out0_data), 32'(tbl[i].e_d0));
      if (tbl[i].e_v1) chk({tbl[i].name, "_d1"}, 32'(out1_data), 32'(tbl[i].e_d1));
      chk({tbl[i].name, "_c0"}, 32'(cnt0), 32'(tbl[i].e_c0));
      chk({tbl[i].name, "_c1"}, 32'(cnt1), 32'(tbl[i].e_c1));
    end

    // Randomized traffic against the queue model.
    do_reset();
    mq0.delete(); mq1.delete(); mc0 = '0; mc1 = '0;
    for (int i = 0; i < 400; i++) begin
      logic       v, s, r0, r1, rdy, p0, p1;
      logic [3:0] d;
      v  = 1'($urandom_range(0, 3) != 0);
      s  = 1'($urandom);
      d  = 4'($urandom);
      r0 = 1'($urandom_range(0, 2) != 0);
      r1 = 1'($urandom_range(0, 3) == 0);
      @(negedge clk);
      drive(v, s, d, r0, r1);
      #1;
      rdy = s ? (mq1.size() < DEPTH) : (mq0.size() < DEPTH);
      chk("rnd_rdy", 32'(in_ready), 32'(rdy));
      chk("rnd_v0", 32'(out0_valid), 32'(mq0.size() != 0));
      chk("rnd_v1", 32'(out1_valid), 32'(mq1.size() != 0));
      if (mq0.size() != 0) chk("rnd_d0", 32'(out0_data), 32'(mq0[0]));
      if (mq1.size() != 0) chk("rnd_d1", 32'(out1_data), 32'(mq1[0]));
      chk("rnd_c0", 32'(cnt0), 32'(mc0));
      chk("rnd_c1", 32'(cnt1), 32'(mc1));
      p0 = r0 && (mq0.size() != 0);
      p1 = r1 && (mq1.size() != 0);
      @(posedge clk);
      if (p0) begin void'(mq0.pop_front()); mc0 = mc0 + 8'd1; end
      if (p1) begin void'(mq1.pop_front()); mc1 = mc1 + 8'd1; end
      if (v && rdy) begin
        if (s) mq1.push_back(d);
        else   mq0.push_back(d);
      end
    end

    // Asynchronous reset with both FIFOs holding words.
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("t6_pre_v0", 32'(out0_valid), 1);
    chk("t6_pre_v1", 32'(out1_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_v0", 32'(out0_valid), 0);
    chk("t6_v1", 32'(out1_valid), 0);
    chk("t6_d0", 32'(out0_data), 0);
    chk("t6_d1", 32'(out1_data), 0);
    chk("t6_c0", 32'(cnt0), 0);
    chk("t6_c1", 32'(cnt1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_sel = 1'b0;
    #1;
    chk("t6_rdy_sel0", 32'(in_ready), 1);
    in_sel = 1'b1;
    #1;
    chk("t6_rdy_sel1", 32'(in_ready), 1);

    // Counter wrap: continuous stream on out0; deliveries start at edge 2.
    do_reset();
    drive(1'b1, 1'b0, 4'h5, 1'b1, 1'b0);
    for (int e = 1; e <= 257; e++) begin
      @(posedge clk);
      #1;
      if (e == 256) chk("t5_cnt255", 32'(cnt0), 255);
      if (e == 257) chk("t5_wrap0", 32'(cnt0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
